seg_scan_scheduler: RTL and testbench

- Time-multiplexed scan scheduler and source arbiter for the 4-digit 7-segment display of the stopwatch.
- Shares the single BCD-to-segment decoder and digit drivers between two requesters:
  - src0: live 4-digit BCD count.
  - src1: a held value, such as a lap/split snapshot, shown for a fixed number of frames.
- Drives digit enables, the BCD nibble and the decimal point, with dead-time blanking between digits.
- Source switching happens only on frame boundaries, so no frame mixes two sources.

---
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_scan_scheduler.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bus between the stopwatch core and the 7-segment scan scheduler:
// the two display requesters plus the shared digit-driver outputs.
interface seg_scan_if;
  logic [15:0] live_bcd;
  logic [15:0] hold_bcd;
  logic        hold_req;
  logic        hold_cancel;
  logic [3:0]  digit_sel;
  logic [3:0]  bcd_out;
  logic        dp;
  logic        frame_done;
  logic        src_active;

  modport master (
    output live_bcd, hold_bcd, hold_req, hold_cancel,
    input  digit_sel, bcd_out, dp, frame_done, src_active
  );

  modport slave (
    input  live_bcd, hold_bcd, hold_req, hold_cancel,
    output digit_sel, bcd_out, dp, frame_done, src_active
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Time-multiplexed 4-digit scan with live/hold source arbitration on frame
// boundaries. Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_scheduler #(
  parameter int         SCAN_DIV    = 1000,
  parameter int         DEAD_CYCLES = 16,
  parameter int         HOLD_FRAMES = 500,
  parameter logic [3:0] DP_MASK     = 4'b0010
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_LIGHT = DIV_W'(DEAD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    SHOW_LIVE = 2'd0,
    PEND_HOLD = 2'd1,
    SHOW_HOLD = 2'd2,
    PEND_LIVE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        slot;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       hold_buf;
  logic [15:0]       disp_buf;
  logic              disp_src;

  logic [3:0]        sel_p0;
  logic [3:0]        nib_p0;
  logic              dp_p0;
  logic              fdone_p0;

  logic              wrap;
  logic              frame_bnd;
  logic              load_slot;
  logic              light_slot;
  logic [15:0]       src_val;
  logic [3:0]        lit_sel;

  function automatic logic [3:0] pick_nibble(input logic [15:0] val,
                                             input logic [1:0]  s);
    case (s)
      2'd0:    return val[15:12];
      2'd1:    return val[11:8];
      2'd2:    return val[7:4];
      default: return val[3:0];
    endcase
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // True when this digit and every more-significant digit are zero; digit4 never blanks.
  function automatic logic lead_zero(input logic [15:0] val,
                                     input logic [1:0]  s);
    case (s)
      2'd0:    return (val[15:12] == 4'd0);
      2'd1:    return (val[15:8]  == 8'd0);
      2'd2:    return (val[15:4]  == 12'd0);
      default: return 1'b0;
    endcase
  endfunction
`endif

  assign wrap       = (div_cnt == DIV_LAST);
  assign frame_bnd  = wrap && (slot == 2'd3);
  assign load_slot  = (div_cnt == '0);
  assign light_slot = (div_cnt == DIV_LIGHT);

  // disp_buf, not hold_buf, feeds the display so a relatch never tears a frame.
  assign src_val = disp_src ? disp_buf : bus.live_bcd;

  always_comb begin
    lit_sel = onehot(slot);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (lead_zero(src_val, slot)) lit_sel = 4'b0000;
`endif
  end

  // ---- scan stage: slot timing, nibble load, digit enable ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      slot     <= 2'd0;
      sel_p0   <= 4'b0000;
      nib_p0   <= 4'd0;
      dp_p0    <= 1'b0;
      fdone_p0 <= 1'b0;
    end else begin
      fdone_p0 <= frame_bnd;
      if (wrap) begin
        div_cnt <= '0;
        slot    <= slot + 2'd1;
        sel_p0  <= 4'b0000;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        if (load_slot) begin
          nib_p0 <= pick_nibble(src_val, slot);
          dp_p0  <= DP_MASK[slot];
        end
        if (light_slot) sel_p0 <= lit_sel;
      end
    end
  end

  // ---- arbiter state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SHOW_LIVE;
    else        state <= state_nxt;
  end

  // Requests coinciding with a boundary are applied on top of the boundary move,
  // i.e. they behave as if they arrived just after it.
  always_comb begin
    state_nxt = state;
    if (frame_bnd) begin
      case (state)
        PEND_HOLD: state_nxt = SHOW_HOLD;
        SHOW_HOLD: state_nxt = (hold_cnt == HOLD_LAST) ? SHOW_LIVE : SHOW_HOLD;
        PEND_LIVE: state_nxt = SHOW_LIVE;
        default:   state_nxt = SHOW_LIVE;
      endcase
    end
    if (bus.hold_req)
      state_nxt = PEND_HOLD;
    else if (bus.hold_cancel && (state_nxt != SHOW_LIVE))
      state_nxt = PEND_LIVE;
  end

  // ---- source stage: hold buffer and per-frame displayed source ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf <= 16'd0;
      disp_buf <= 16'd0;
      disp_src <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (bus.hold_req) hold_buf <= bus.hold_bcd;
      if (frame_bnd) begin
        case (state)
          PEND_HOLD: begin
            disp_src <= 1'b1;
            disp_buf <= hold_buf;
            hold_cnt <= '0;
          end
          SHOW_HOLD: begin
            if (hold_cnt == HOLD_LAST) disp_src <= 1'b0;
            else                       hold_cnt <= hold_cnt + 1'b1;
          end
          default: disp_src <= 1'b0;
        endcase
      end
    end
  end

  assign bus.digit_sel  = sel_p0;
  assign bus.bcd_out    = nib_p0;
  assign bus.dp         = dp_p0;
  assign bus.frame_done = fdone_p0;
  assign bus.src_active = disp_src;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed scoreboard bench for seg_scan_scheduler (SCAN_DIV=8, DEAD_CYCLES=2, HOLD_FRAMES=3).
`timescale 1ns/1ps
module tb_seg_scan_scheduler;

  localparam int         SCAN_DIV = 8;
  localparam int         DEAD     = 2;
  localparam int         HOLD     = 3;
  localparam int         FRAME    = 4 * SCAN_DIV;
  localparam logic [3:0] DP_MASK  = 4'b0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_if bus();

  seg_scan_scheduler #(
    .SCAN_DIV   (SCAN_DIV),
    .DEAD_CYCLES(DEAD),
    .HOLD_FRAMES(HOLD),
    .DP_MASK    (DP_MASK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] nib;
    logic       dp;
    logic       src;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur = '0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   phase = 0;
  int   m_in;

  logic [15:0] live_tab [10] = '{16'h1234, 16'hABCF, 16'h0000, 16'h9999, 16'h0045,
                                 16'h0800, 16'hFFFF, 16'h0001, 16'h1234, 16'h5555};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_sel(input logic [15:0] v, input int s);
    logic [3:0] sel;
    sel = 4'b0001 << s;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (s < 3 && (v >> (12 - 4 * s)) == 16'd0) sel = 4'b0000;
`endif
    return sel;
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic src);
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      e.sel = exp_sel(v, s);
      e.nib = v[15 - 4 * s -: 4];
      e.dp  = DP_MASK[s];
      e.src = src;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_done;
    end
    check("frame_wait", seen, 1'b1);
  endtask

  task automatic pulse_req(input logic [15:0] v);
    bus.hold_bcd = v;
    bus.hold_req = 1'b1;
    @(negedge clk);
    bus.hold_req = 1'b0;
  endtask

  task automatic pulse_cancel();
    bus.hold_cancel = 1'b1;
    @(negedge clk);
    bus.hold_cancel = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    phase  = 0;
    mon_en = 1'b1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_digit_sel"},  bus.digit_sel,  4'b0000);
    check({pfx, "_bcd_out"},    bus.bcd_out,    4'd0);
    check({pfx, "_dp"},         bus.dp,         1'b0);
    check({pfx, "_frame_done"}, bus.frame_done, 1'b0);
    check({pfx, "_src_active"}, bus.src_active, 1'b0);
  endtask

  // Cycle monitor: timing model of the scan plus scoreboard pop at each digit light-up.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        m_in = phase % SCAN_DIV;
        if (m_in == DEAD) begin
          check("queue_nonempty", (exp_q.size() != 0), 1'b1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("bcd_out",    bus.bcd_out,    cur.nib);
            check("dp",         bus.dp,         cur.dp);
            check("src_active", bus.src_active, cur.src);
          end
        end
        check("digit_sel", bus.digit_sel, (m_in < DEAD) ? 4'b0000 : cur.sel);
        check("frame_done", bus.frame_done, ((phase % FRAME) == 0) && (phase != 0));
        phase++;
      end
    end
  end

  initial begin
    bus.live_bcd    = 16'h1234;
    bus.hold_bcd    = 16'h0000;
    bus.hold_req    = 1'b0;
    bus.hold_cancel = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");

    // Live scan of 1234, then ten frames of assorted live values
    release_reset();
    push_frame(16'h1234, 1'b0);
    for (int f = 0; f < 10; f++) begin
      wait_frame();
      bus.live_bcd = live_tab[f];
      push_frame(live_tab[f], 1'b0);
    end

    // Mid-frame hold request: rest of frame live, then HOLD frames of 0987
    step(10);
    pulse_req(16'h0987);
    for (int f = 0; f < HOLD; f++) begin
      wait_frame();
      push_frame(16'h0987, 1'b1);
    end
    wait_frame();
    push_frame(16'h5555, 1'b0);

    // Re-request during hold frame 2: 1 + 1 + HOLD frames of hold
    step(5);
    pulse_req(16'h0987);
    wait_frame();
    push_frame(16'h0987, 1'b1);
    wait_frame();
    push_frame(16'h0987, 1'b1);
    step(12);
    pulse_req(16'h0111);
    for (int f = 0; f < HOLD; f++) begin
      wait_frame();
      push_frame(16'h0111, 1'b1);
    end
    wait_frame();
    push_frame(16'h5555, 1'b0);

    // Cancel while live is ignored; cancel in hold frame 1 returns to live
    step(3);
    pulse_cancel();
    wait_frame();
    push_frame(16'h5555, 1'b0);
    step(7);
    pulse_req(16'h0987);
    wait_frame();
    push_frame(16'h0987, 1'b1);
    step(9);
    pulse_cancel();
    wait_frame();
    push_frame(16'h5555, 1'b0);

    // Request and cancel together: request wins and restarts the hold
    step(7);
    pulse_req(16'h0987);
    wait_frame();
    push_frame(16'h0987, 1'b1);
    step(9);
    bus.hold_bcd    = 16'h0222;
    bus.hold_req    = 1'b1;
    bus.hold_cancel = 1'b1;
    @(negedge clk);
    bus.hold_req    = 1'b0;
    bus.hold_cancel = 1'b0;
    for (int f = 0; f < HOLD; f++) begin
      wait_frame();
      push_frame(16'h0222, 1'b1);
    end
    wait_frame();
    push_frame(16'h5555, 1'b0);

    // Request on the boundary edge switches one frame later
    step(FRAME - 1);
    bus.hold_bcd = 16'h0333;
    bus.hold_req = 1'b1;
    wait_frame();
    bus.hold_req = 1'b0;
    push_frame(16'h5555, 1'b0);
    for (int f = 0; f < HOLD; f++) begin
      wait_frame();
      push_frame(16'h0333, 1'b1);
    end
    wait_frame();
    push_frame(16'h5555, 1'b0);

    // Reset while digit3 is lit in a hold frame
    step(5);
    pulse_req(16'h0987);
    wait_frame();
    push_frame(16'h0987, 1'b1);
    step(2 * SCAN_DIV + 4);
    check("pre_rst_digit_sel",  bus.digit_sel,  4'b0100);
    check("pre_rst_src_active", bus.src_active, 1'b1);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    bus.live_bcd = 16'h0045;
    repeat (2) @(posedge clk);
    release_reset();
    push_frame(16'h0045, 1'b0);
    wait_frame();
    push_frame(16'h0045, 1'b0);
    step(FRAME - 2);
    check("queue_drained", exp_q.size(), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
